mem_wb_stage: RTL

MEM/WB pipeline boundary of the five-stage core, directly upstream of the 32×32 register file's write port. It registers the memory-stage result under the global stall/flush controls, aligns and sign/zero-extends load data, and blocks misaligned loads. It also holds the architectural HI/LO pair, committing it one cycle after write-back, with a bypassed read path.

---
 rtl/mem_wb_stage_pkg.sv | 20 ++
 rtl/mem_wb_stage_load_align.sv | 53 +++++
 rtl/mem_wb_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB boundary: bus widths, enable levels
// and the load-type encoding carried from the memory stage.
package mem_wb_stage_pkg;

  localparam int unsigned REG_BUS_W      = 32;
  localparam int unsigned REG_ADDR_BUS_W = 5;
  localparam int unsigned LD_TYPE_W      = 3;
  localparam logic        RST_ENABLE     = 1'b1;
  localparam logic        WRITE_ENABLE   = 1'b1;

  typedef enum logic [LD_TYPE_W-1:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } ld_type_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load aligner: picks the big-endian byte/halfword lane,
// extends it to the register width and flags misaligned accesses.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [LD_TYPE_W-1:0] ld_type,
  input  logic [1:0]           addr_lo,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [DATA_W-1:0]    alu_data,
  output logic [DATA_W-1:0]    data,
  output logic                 misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    w_byte = rdata[DATA_W-1  -: 8];
      2'd1:    w_byte = rdata[DATA_W-9  -: 8];
      2'd2:    w_byte = rdata[DATA_W-17 -: 8];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr_lo[1] ? rdata[15:0] : rdata[DATA_W-1 -: 16];
  end

  // Encodings 6 and 7 fall through to the non-load path.
  always_comb begin
    data     = alu_data;
    misalign = 1'b0;
    case (ld_type)
      LD_LB:  data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LBU: data = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LH: begin
        data     = {{(DATA_W-16){w_half[15]}}, w_half};
        misalign = addr_lo[0];
      end
      LD_LHU: begin
        data     = {{(DATA_W-16){1'b0}}, w_half};
        misalign = addr_lo[0];
      end
      LD_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'd0);
      end
      default: data = alu_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register feeding the register-file write port, plus the
// architectural HI/LO pair committed one cycle after write-back.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_mem,
  input  logic                 stall_wb,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    mem_wd,
  input  logic                 mem_wreg,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [LD_TYPE_W-1:0] mem_ld_type,
  input  logic [1:0]           mem_addr_lo,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_whilo,
  input  logic [DATA_W-1:0]    mem_hi,
  input  logic [DATA_W-1:0]    mem_lo,
  output logic [ADDR_W-1:0]    wb_wd,
  output logic                 wb_wreg,
  output logic [DATA_W-1:0]    wb_wdata,
  output logic                 wb_misalign,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o
);

  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_misalign;

  logic [ADDR_W-1:0] r_wd;
  logic              r_wreg;
  logic [DATA_W-1:0] r_wdata;
  logic              r_misalign;
  logic              r_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi_reg;
  logic [DATA_W-1:0] r_lo_reg;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .ld_type  (mem_ld_type),
    .addr_lo  (mem_addr_lo),
    .rdata    (mem_rdata),
    .alu_data (mem_wdata),
    .data     (w_ld_data),
    .misalign (w_ld_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_wd       <= '0;
      r_wreg     <= 1'b0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
      r_whilo    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_hi_reg   <= '0;
      r_lo_reg   <= '0;
    end else begin
      // The instruction in WB has already retired, so a flush must not cancel its commit.
      if (r_whilo && !stall_wb) begin
        r_hi_reg <= r_hi;
        r_lo_reg <= r_lo;
      end
      if (flush || (stall_mem && !stall_wb)) begin
        r_wd       <= '0;
        r_wreg     <= 1'b0;
        r_wdata    <= '0;
        r_misalign <= 1'b0;
        r_whilo    <= 1'b0;
        r_hi       <= '0;
        r_lo       <= '0;
      end else if (!stall_mem) begin
        r_wd       <= mem_wd;
        r_wreg     <= (mem_wreg == WRITE_ENABLE) && !w_ld_misalign;
        r_wdata    <= w_ld_data;
        r_misalign <= w_ld_misalign;
        r_whilo    <= mem_whilo;
        r_hi       <= mem_hi;
        r_lo       <= mem_lo;
      end
    end
  end

  always_comb begin
    wb_wd       = r_wd;
    wb_wreg     = r_wreg;
    wb_wdata    = r_wdata;
    wb_misalign = r_misalign;
    hi_o        = r_whilo ? r_hi : r_hi_reg;
    lo_o        = r_whilo ? r_lo : r_lo_reg;
  end

endmodule
